// File: rtl/fu_shift.sv
// rtl/fu_shift.sv - multi-cycle SLL/SRL/SRA/ROR shift unit with issue tag
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   ce       issue strobe; op, data_0, data_1 and tag_in are sampled when high
//   op       00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_0   shift amount; only the low $clog2(DATA_WIDTH) bits are used
//   data_1   value to be shifted
//   tag_in   issue tag
//   idle     unit can accept ce this cycle (idle flag AND NOT ce)
//   done     one-cycle registered completion pulse
//   result   registered result, held until the next completion or reset
//   tag_out  tag of the completed operation
module fu_shift #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  idle,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(LATENCY + 1) + 1;

    logic [SHW-1:0]        shamt_q, shamt_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [1:0]            op_q, op_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  idle_q, idle_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic [SHW-1:0]        rot_l;
    logic                  complete;

    // Upper amount bits are ignored by design; reduce them into a sink.
    logic unused_amt_bits;
    assign unused_amt_bits = ^data_0[DATA_WIDTH-1:SHW];

    always_comb begin
        // Left half of the rotate: DATA_WIDTH - shamt modulo DATA_WIDTH,
        // so shamt=0 gives a zero left shift and the value passes unchanged.
        rot_l = SHW'(0) - shamt_q;
        case (op_q)
            2'b00:   shifted = val_q << shamt_q;
            2'b01:   shifted = val_q >> shamt_q;
            2'b10:   shifted = $unsigned($signed(val_q) >>> shamt_q);
            default: shifted = (val_q >> shamt_q) | (val_q << rot_l);
        endcase
    end

    assign complete = run_q && (cnt_q == CW'(LATENCY));

    always_comb begin
        shamt_d   = shamt_q;
        val_d     = val_q;
        op_d      = op_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        idle_d    = idle_q;
        done_d    = 1'b0;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        if (complete) begin
            result_d  = shifted;
            tag_out_d = tag_q;
            done_d    = 1'b1;
            run_d     = 1'b0;
            idle_d    = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1);
        end

        // A new issue wins over the counter: it either follows a completion
        // in the same edge or replaces (aborts) the in-flight operation.
        if (ce) begin
            shamt_d = data_0[SHW-1:0];
            val_d   = data_1;
            op_d    = op;
            tag_d   = tag_in;
            cnt_d   = CW'(1);
            run_d   = 1'b1;
            idle_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shamt_q   <= '0;
            val_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            shamt_q   <= shamt_d;
            val_q     <= val_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign idle    = idle_q & ~ce;
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_fu_shift.sv
// tb/tb_fu_shift.sv - scoreboard bench for fu_shift (32b/LAT4 and 64b/LAT1)
module tb_fu_shift;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  tag;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        ce0 = 1'b0, ce1 = 1'b0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, v0 = '0;
    logic [63:0] a1 = '0, v1 = '0;
    logic [5:0]  tag0 = '0, tag1 = '0;
    logic        idle0, idle1, done0, done1;
    logic [31:0] res0;
    logic [63:0] res1;
    logic [5:0]  tout0, tout1;

    fu_shift #(.DATA_WIDTH(32), .LATENCY(4), .TAG_WIDTH(6)) u0 (
        .clk(clk), .rst(rst), .ce(ce0), .op(op0), .data_0(a0), .data_1(v0),
        .tag_in(tag0), .idle(idle0), .done(done0), .result(res0), .tag_out(tout0)
    );

    fu_shift #(.DATA_WIDTH(64), .LATENCY(1), .TAG_WIDTH(6)) u1 (
        .clk(clk), .rst(rst), .ce(ce1), .op(op1), .data_0(a1), .data_1(v1),
        .tag_in(tag1), .idle(idle1), .done(done1), .result(res1), .tag_out(tout1)
    );

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    int          busy_until[2];
    logic [63:0] last_res[2];
    logic [5:0]  last_tag[2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: rules applied with plain arithmetic on a 64-bit container.
    function automatic logic [63:0] ref_shift(int w, logic [1:0] o,
                                              logic [63:0] a, logic [63:0] v);
        logic [63:0] mask, r;
        int s;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s = int'(a % 64'(w));
        v = v & mask;
        case (o)
            2'b00: r = (v << s) & mask;
            2'b01: r = v >> s;
            2'b10: begin
                r = v >> s;
                if (v[w-1]) r = r | (mask & ~(mask >> s));
            end
            default: begin
                r = v;
                for (int i = 0; i < s; i++)
                    r = (r >> 1) | (r[0] ? (64'd1 << (w - 1)) : 64'd0);
            end
        endcase
        return r;
    endfunction

    task automatic clear_model();
        q0.delete();
        q1.delete();
        busy_until[0] = 0;
        busy_until[1] = 0;
        last_res[0] = '0;
        last_res[1] = '0;
        last_tag[0] = '0;
        last_tag[1] = '0;
    endtask

    task automatic issue(int u, logic [1:0] o, logic [63:0] a, logic [63:0] v,
                         logic [5:0] t, bit use_lit, logic [63:0] lit);
        exp_t e;
        int c0;
        int w;
        int lat;
        w   = (u == 0) ? 32 : 64;
        lat = (u == 0) ? 4 : 1;
        @(negedge clk);
        if (u == 0) begin
            ce0 = 1'b1; op0 = o; a0 = a[31:0]; v0 = v[31:0]; tag0 = t;
        end else begin
            ce1 = 1'b1; op1 = o; a1 = a; v1 = v; tag1 = t;
        end
        #1;
        chk("idle_low_with_ce", (u == 0) ? {63'd0, idle0} : {63'd0, idle1}, 64'd0);
        @(posedge clk);
        #1;
        if (u == 0) ce0 = 1'b0; else ce1 = 1'b0;
        c0 = cyc;
        // An operation still in flight past this edge is aborted.
        if (busy_until[u] > c0) begin
            if (u == 0 && q0.size() > 0) void'(q0.pop_back());
            if (u == 1 && q1.size() > 0) void'(q1.pop_back());
        end
        e.res = use_lit ? lit : ref_shift(w, o, a, v);
        e.tag = t;
        e.cyc = c0 + lat;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        busy_until[u] = c0 + lat;
    endtask

    task automatic mon(int u, logic d, logic [63:0] r, logic [5:0] tg);
        exp_t e;
        if (d) begin
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                chk(u == 0 ? "u0_unexpected_done" : "u1_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                chk(u == 0 ? "u0_result" : "u1_result", r, e.res);
                chk(u == 0 ? "u0_tag_out" : "u1_tag_out", {58'd0, tg}, {58'd0, e.tag});
                chk(u == 0 ? "u0_done_cycle" : "u1_done_cycle", 64'(cyc), 64'(e.cyc));
                last_res[u] = e.res;
                last_tag[u] = e.tag;
            end
        end else begin
            chk(u == 0 ? "u0_result_hold" : "u1_result_hold", r, last_res[u]);
            chk(u == 0 ? "u0_tag_hold" : "u1_tag_hold", {58'd0, tg}, {58'd0, last_tag[u]});
        end
    endtask

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst) begin
            mon(0, done0, {32'd0, res0}, tout0);
            mon(1, done1, res1, tout1);
        end
    end

    task automatic drain();
        int budget;
        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset release.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_done", {63'd0, done0}, 64'd0);
            chk("rst_result", {32'd0, res0}, 64'd0);
            chk("rst_tag_out", {58'd0, tout0}, 64'd0);
            chk("rst_idle", {63'd0, idle0}, 64'd1);
            chk("rst_done64", {63'd0, done1}, 64'd0);
        end
        mon_en = 1'b1;

        // SRA with idle profile.
        issue(0, 2'b10, 64'd4, 64'h8000_00F0, 6'd5, 1'b1, 64'hF800_000F);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_busy", {63'd0, idle0}, 64'd0);
        end
        @(negedge clk);
        chk("idle_done_cycle", {63'd0, idle0}, 64'd1);
        drain();

        // Modes and amount masking.
        issue(0, 2'b00, 64'h24, 64'h1234_5678, 6'd10, 1'b1, 64'h2345_6780);
        drain();
        issue(0, 2'b01, 64'd8, 64'h1234_5678, 6'd11, 1'b1, 64'h0012_3456);
        drain();
        issue(0, 2'b11, 64'd8, 64'h1234_5678, 6'd12, 1'b1, 64'h7812_3456);
        drain();
        issue(0, 2'b11, 64'd0, 64'h1234_5678, 6'd13, 1'b1, 64'h1234_5678);
        drain();
        issue(0, 2'b01, 64'd32, 64'hCAFE_F00D, 6'd14, 1'b1, 64'hCAFE_F00D);
        drain();

        // Back-to-back: B issued in A's done cycle.
        issue(0, 2'b00, 64'd1, 64'h0000_0011, 6'd1, 1'b1, 64'h0000_0022);
        repeat (4) @(posedge clk);
        issue(0, 2'b01, 64'd4, 64'h0000_0F00, 6'd2, 1'b1, 64'h0000_00F0);
        drain();

        // ce coinciding with the completion edge.
        issue(0, 2'b11, 64'd4, 64'h0000_00AB, 6'd20, 1'b1, 64'hB000_000A);
        repeat (3) @(posedge clk);
        issue(0, 2'b10, 64'd31, 64'h8000_0000, 6'd21, 1'b1, 64'hFFFF_FFFF);
        drain();

        // Abort by reissue: only tag 4 completes, after edge 6.
        issue(0, 2'b00, 64'd3, 64'h0000_0001, 6'd3, 1'b1, 64'h0000_0008);
        @(posedge clk);
        issue(0, 2'b00, 64'd5, 64'h0000_0001, 6'd4, 1'b1, 64'h0000_0020);
        drain();

        // Asynchronous reset mid-operation.
        issue(0, 2'b01, 64'd1, 64'hFFFF_FFFF, 6'd30, 1'b0, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        chk("async_rst_done", {63'd0, done0}, 64'd0);
        chk("async_rst_result", {32'd0, res0}, 64'd0);
        chk("async_rst_tag_out", {58'd0, tout0}, 64'd0);
        chk("async_rst_idle", {63'd0, idle0}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        issue(0, 2'b00, 64'd16, 64'h0000_ABCD, 6'd31, 1'b1, 64'hABCD_0000);
        drain();

        // 64-bit, LATENCY=1.
        issue(1, 2'b10, 64'd48, 64'hFFFF_0000_0000_0000, 6'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        issue(1, 2'b11, 64'd4, 64'h0123_4567_89AB_CDEF, 6'd8, 1'b1, 64'hF012_3456_789A_BCDE);
        issue(1, 2'b00, 64'd68, 64'h0000_0000_0000_0001, 6'd9, 1'b1, 64'h0000_0000_0000_0010);
        drain();

        // Randomized traffic on both units, including reissue and
        // completion-edge overlaps.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            issue(n % 2, 2'($urandom_range(0, 3)),
                  {32'($urandom), 32'($urandom)},
                  {32'($urandom), 32'($urandom)},
                  6'($urandom), 1'b0, 64'd0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
